// File: rtl/shift_add_mult8.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module  : shift_add_mult8
//  Purpose : sequential signed N x N shift-add multiplier (external add/sub stage)
//  Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module shift_add_mult8 #(
  parameter int N = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Run,
  input  logic         ClearA_LoadB,
  input  logic [N-1:0] Din,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_fn,
  input  logic [N:0]   add_sum,
  output logic [N-1:0] Aval,
  output logic [N-1:0] Bval,
  output logic         Xval,
  output logic         busy,
  output logic         done
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  s_reg;
  logic          x_reg;
  logic [CW-1:0] cnt;

  // busy/done/add_fn are registered alongside the state so every output is a flop
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      s_reg  <= '0;
      x_reg  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      add_fn <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            x_reg <= 1'b0;
            a_reg <= '0;
            b_reg <= Din;
          end else if (Run) begin
            s_reg  <= Din;
            x_reg  <= 1'b0;
            a_reg  <= '0;
            cnt    <= '0;
            state  <= ADD;
            busy   <= 1'b1;
            add_fn <= (LAST == '0);
          end
        end

        ADD: begin
          if (b_reg[0]) begin
            {x_reg, a_reg} <= add_sum;
          end
          add_fn <= 1'b0;
          state  <= SHIFT;
        end

        SHIFT: begin
          a_reg <= {x_reg, a_reg[N-1:1]};
          b_reg <= {a_reg[0], b_reg[N-1:1]};
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            // last iteration subtracts: the multiplier MSB carries weight -2^(N-1)
            cnt    <= cnt + ONE;
            add_fn <= ((cnt + ONE) == LAST);
            state  <= ADD;
          end
        end

        DONE: begin
          if (!Run) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          add_fn <= 1'b0;
        end
      endcase
    end
  end

  assign add_a = a_reg;
  assign add_b = s_reg;
  assign Aval  = a_reg;
  assign Bval  = b_reg;
  assign Xval  = x_reg;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult8.sv
`default_nettype none
// Bench for shift_add_mult8: models the external add/sub stage and checks
// products against plain signed multiplication.
module tb_shift_add_mult8;

  logic        Clk;
  logic        Reset;
  logic        Run;
  logic        ClearA_LoadB;
  logic [7:0]  Din;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_fn;
  logic [8:0]  add_sum;
  logic [7:0]  Aval;
  logic [7:0]  Bval;
  logic        Xval;
  logic        busy;
  logic        done;

  int compared;
  int mismatched;

  shift_add_mult8 #(.N(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .Din          (Din),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_fn       (add_fn),
    .add_sum      (add_sum),
    .Aval         (Aval),
    .Bval         (Bval),
    .Xval         (Xval),
    .busy         (busy),
    .done         (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // external 9-bit sign-extended add/subtract stage
  always_comb begin
    add_sum = add_fn ? ({add_a[7], add_a} - {add_b[7], add_b})
                     : ({add_a[7], add_a} + {add_b[7], add_b});
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; Din = 8'hA5;
    step(); step(); step();
    compared++;
    if ({Aval, Bval, Xval} !== 17'd0) begin
      mismatched++;
      $display("FAIL reset_regs: got A=%h B=%h X=%b, want all zero", Aval, Bval, Xval);
    end
    compared++;
    if ({busy, done, add_fn} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_flags: got busy=%b done=%b add_fn=%b, want 000", busy, done, add_fn);
    end
    compared++;
    if (add_b !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_s: got add_b=%h, want 00", add_b);
    end
    Reset = 1'b0;
    step();
  endtask

  // full multiply of b * s with checks; optionally holds Run high in DONE
  task automatic run_mult(input logic [7:0] b, input logic [7:0] s, input bit hold_run);
    int          pe;
    logic [15:0] exp_p;
    int          busy_n, fn_n, fn_idx, guard;
    bit          s_ok, hold_ok;
    pe    = $signed(b) * $signed(s);
    exp_p = pe[15:0];

    ClearA_LoadB = 1'b1; Din = b; Run = 1'b0;
    step();
    ClearA_LoadB = 1'b0; Din = s; Run = 1'b1;
    step();
    busy_n = 0; fn_n = 0; fn_idx = -1; guard = 0; s_ok = 1'b1;
    while (!done && guard < 40) begin
      if (busy) begin
        if (add_fn) begin
          fn_n++;
          fn_idx = busy_n;
        end
        if (add_b !== s) s_ok = 1'b0;
        busy_n++;
      end
      Din = 8'($urandom);
      ClearA_LoadB = 1'($urandom);
      guard++;
      step();
    end
    ClearA_LoadB = 1'b0;

    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL done_timeout: b=%h s=%h done=%b after %0d cycles, want 1", b, s, done, guard);
    end
    compared++;
    if (busy_n !== 16) begin
      mismatched++;
      $display("FAIL busy_cycles: b=%h s=%h got %0d, want 16", b, s, busy_n);
    end
    compared++;
    if ({fn_n, fn_idx} !== {32'd1, 32'd14}) begin
      mismatched++;
      $display("FAIL add_fn_window: b=%h s=%h got count=%0d at busy cycle %0d, want 1 at 14", b, s, fn_n, fn_idx);
    end
    compared++;
    if (!s_ok) begin
      mismatched++;
      $display("FAIL s_stable: b=%h s=%h add_b changed during multiply, want %h", b, s, s);
    end
    compared++;
    if ({Aval, Bval} !== exp_p) begin
      mismatched++;
      $display("FAIL product: b=%h s=%h got %h, want %h", b, s, {Aval, Bval}, exp_p);
    end
    compared++;
    if (Xval !== exp_p[15]) begin
      mismatched++;
      $display("FAIL x_sign: b=%h s=%h got %b, want %b", b, s, Xval, exp_p[15]);
    end
    compared++;
    if ({busy, add_fn} !== 2'b00) begin
      mismatched++;
      $display("FAIL done_flags: b=%h s=%h got busy=%b add_fn=%b, want 00", b, s, busy, add_fn);
    end

    if (hold_run) begin
      hold_ok = 1'b1;
      for (int i = 0; i < 22; i++) begin
        Din = 8'($urandom);
        ClearA_LoadB = 1'($urandom);
        step();
        if (done !== 1'b1 || busy !== 1'b0 || {Aval, Bval} !== exp_p || Xval !== exp_p[15])
          hold_ok = 1'b0;
      end
      ClearA_LoadB = 1'b0;
      compared++;
      if (!hold_ok) begin
        mismatched++;
        $display("FAIL run_held: done=%b busy=%b product=%h, want done=1 busy=0 product=%h", done, busy, {Aval, Bval}, exp_p);
      end
    end

    Run = 1'b0;
    step();
    compared++;
    if ({done, busy} !== 2'b00) begin
      mismatched++;
      $display("FAIL release_idle: got done=%b busy=%b, want 00", done, busy);
    end
    compared++;
    if ({Aval, Bval} !== exp_p) begin
      mismatched++;
      $display("FAIL idle_hold: got %h, want %h", {Aval, Bval}, exp_p);
    end
  endtask

  task automatic test_directed();
    run_mult(8'hFD, 8'h07, 1'b0);
    run_mult(8'h80, 8'h80, 1'b0);
    run_mult(8'h00, 8'h5A, 1'b0);
    run_mult(8'hFF, 8'hFF, 1'b0);
    run_mult(8'h7F, 8'h80, 1'b0);
    run_mult(8'h80, 8'h7F, 1'b0);
    run_mult(8'h7F, 8'h7F, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_mult(8'($urandom), 8'($urandom), 1'b0);
    end
  endtask

  task automatic test_run_held();
    run_mult(8'hC9, 8'h35, 1'b1);
  endtask

  task automatic test_reset_mid();
    ClearA_LoadB = 1'b1; Din = 8'h5B; Run = 1'b0;
    step();
    ClearA_LoadB = 1'b0; Din = 8'hC3; Run = 1'b1;
    step();
    // busy cycle 8 is the fifth ADD state
    for (int i = 0; i < 8; i++) step();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_busy: got busy=%b, want 1", busy);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0; Run = 1'b0;
    compared++;
    if ({Aval, Bval, Xval, add_b} !== 25'd0) begin
      mismatched++;
      $display("FAIL mid_reset_regs: got A=%h B=%h X=%b S=%h, want all zero", Aval, Bval, Xval, add_b);
    end
    compared++;
    if ({busy, done, add_fn} !== 3'b000) begin
      mismatched++;
      $display("FAIL mid_reset_flags: got busy=%b done=%b add_fn=%b, want 000", busy, done, add_fn);
    end
    step();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset_idle: got busy=%b one cycle later, want 0", busy);
    end
  endtask

  task automatic test_load_priority();
    logic [7:0] v;
    v = 8'($urandom) | 8'h01;
    ClearA_LoadB = 1'b1; Run = 1'b1; Din = v;
    step();
    compared++;
    if ({busy, done} !== 2'b00) begin
      mismatched++;
      $display("FAIL load_no_start: got busy=%b done=%b, want 00", busy, done);
    end
    compared++;
    if ({Aval, Bval, Xval} !== {8'h00, v, 1'b0}) begin
      mismatched++;
      $display("FAIL load_b: got A=%h B=%h X=%b, want A=00 B=%h X=0", Aval, Bval, Xval, v);
    end
    step();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL load_hold_idle: got busy=%b, want 0", busy);
    end
    ClearA_LoadB = 1'b0; Run = 1'b0;
    step();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; Din = 8'h00;
    test_reset();
    test_directed();
    test_load_priority();
    test_run_held();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
